// File: rtl/logmul_arbiter_if.sv
// Request/response bundle between two requesters, one result consumer and the
// shared log-multiplier arbiter.
interface logmul_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [7:0]  req0_a;
  logic [7:0]  req0_b;
  logic        req1_valid;
  logic        req1_ready;
  logic [7:0]  req1_a;
  logic [7:0]  req1_b;
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] resp_data;
  logic        resp_id;

  modport slave (
    input  req0_valid, req0_a, req0_b,
    input  req1_valid, req1_a, req1_b,
    input  resp_ready,
    output req0_ready, req1_ready,
    output resp_valid, resp_data, resp_id
  );

  modport master (
    output req0_valid, req0_a, req0_b,
    output req1_valid, req1_a, req1_b,
    output resp_ready,
    input  req0_ready, req1_ready,
    input  resp_valid, resp_data, resp_id
  );
endinterface

// File: rtl/logmul_arbiter.sv
// Round-robin sharing of one combinational antilog multiplier between two
// requesters; operands are held for MUL_LAT cycles before the product is captured.
module logmul_arbiter #(
  parameter int MUL_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  logmul_arbiter_if.slave bus,
  output logic [7:0]  mul_a,
  output logic [7:0]  mul_b,
  input  logic [15:0] mul_c,
  output logic        busy,
  output logic [15:0] ops_done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [3:0] CNT_INIT = 4'(MUL_LAT - 1);

  logic [1:0]  r_state;
  logic        r_last_grant;
  logic [7:0]  r_op_a;
  logic [7:0]  r_op_b;
  logic [3:0]  r_cnt;
  logic        r_id;
  logic [15:0] r_resp_data;
  logic [15:0] r_ops_done;

  logic        w_idle;
  logic        w_grant0;
  logic        w_grant1;
  logic        w_hs0;
  logic        w_hs1;

  // The log path has no meaning at zero, so a zero operand forces a zero product.
  function automatic logic [15:0] f_capture(input logic [7:0] a,
                                            input logic [7:0] b,
                                            input logic [15:0] c);
    return ((a == 8'd0) || (b == 8'd0)) ? 16'd0 : c;
  endfunction

  assign w_idle   = (r_state == S_IDLE);
  assign w_grant0 = bus.req0_valid & (~bus.req1_valid | r_last_grant);
  assign w_grant1 = bus.req1_valid & (~bus.req0_valid | ~r_last_grant);

  assign bus.req0_ready = w_idle & w_grant0 & ~rst;
  assign bus.req1_ready = w_idle & w_grant1 & ~rst;
  assign w_hs0 = bus.req0_ready;
  assign w_hs1 = bus.req1_ready;

  assign mul_a          = r_op_a;
  assign mul_b          = r_op_b;
  assign bus.resp_valid = (r_state == S_RESP);
  assign bus.resp_data  = r_resp_data;
  assign bus.resp_id    = r_id;
  assign busy           = ~w_idle;
  assign ops_done       = r_ops_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_op_a       <= 8'd0;
      r_op_b       <= 8'd0;
      r_cnt        <= 4'd0;
      r_id         <= 1'b0;
      r_resp_data  <= 16'd0;
      r_ops_done   <= 16'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_hs0 | w_hs1) begin
            r_op_a  <= w_hs1 ? bus.req1_a : bus.req0_a;
            r_op_b  <= w_hs1 ? bus.req1_b : bus.req0_b;
            r_id    <= w_hs1;
            r_cnt   <= CNT_INIT;
            r_state <= S_WAIT;
          end
        end
        // Operands stay on the multiplier until the settle count expires.
        S_WAIT: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_resp_data <= f_capture(r_op_a, r_op_b, mul_c);
            r_state     <= S_RESP;
          end
        end
        S_RESP: begin
          if (bus.resp_ready) begin
            r_state      <= S_IDLE;
            r_last_grant <= r_id;
            r_ops_done   <= r_ops_done + 16'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_logmul_arbiter.sv
// Bench for logmul_arbiter: exact-product multiplier stub plus a 0xBEEF mode,
// randomized operands checked against an arithmetic reference model.
module tb_logmul_arbiter;
  localparam int LAT  = 1;
  localparam int LAT4 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rst4, stub_beef;
  logic [7:0]  mul_a, mul_b, mul_a4, mul_b4;
  logic [15:0] mul_c, mul_c4, ops_done, ops_done4;
  logic        busy, busy4;

  logmul_arbiter_if bif();
  logmul_arbiter_if bif4();

  assign mul_c  = stub_beef ? 16'hBEEF : 16'(int'(mul_a) * int'(mul_b));
  assign mul_c4 = 16'(int'(mul_a4) * int'(mul_b4));

  logmul_arbiter #(.MUL_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .bus(bif), .mul_a(mul_a), .mul_b(mul_b),
    .mul_c(mul_c), .busy(busy), .ops_done(ops_done));

  logmul_arbiter #(.MUL_LAT(LAT4)) dut4 (
    .clk(clk), .rst(rst4), .bus(bif4), .mul_a(mul_a4), .mul_b(mul_b4),
    .mul_c(mul_c4), .busy(busy4), .ops_done(ops_done4));

  int total = 0;
  int bad = 0;
  int exp_ops = 0;
  int model_last = 1;

  function automatic int ref_prod(input int a, input int b, input bit beef);
    if (a == 0 || b == 0) return 0;
    return beef ? 'hBEEF : a * b;
  endfunction

  task automatic test_reset();
    rst = 1'b1; rst4 = 1'b1;
    bif.req0_valid = 1'b1; bif.req0_a = 8'd5; bif.req0_b = 8'd6;
    bif.req1_valid = 1'b0; bif.req1_a = 8'd0; bif.req1_b = 8'd0;
    bif.resp_ready = 1'b0;
    @(posedge clk);
    repeat (3) begin
      @(negedge clk); #1;
      total++;
      if (bif.req0_ready !== 1'b0 || bif.req1_ready !== 1'b0) begin
        bad++;
        $display("FAIL reset_ready: req0_ready=%b req1_ready=%b required 0 0",
                 bif.req0_ready, bif.req1_ready);
      end
      total++;
      if (bif.resp_valid !== 1'b0 || busy !== 1'b0 || bif.resp_id !== 1'b0 ||
          bif.resp_data !== 16'd0 || ops_done !== 16'd0 || mul_a !== 8'd0 || mul_b !== 8'd0) begin
        bad++;
        $display("FAIL reset_outputs: valid=%b busy=%b id=%b data=%h ops=%h mul=%h/%h required all zero",
                 bif.resp_valid, busy, bif.resp_id, bif.resp_data, ops_done, mul_a, mul_b);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0; rst4 = 1'b0;
    @(negedge clk); #1;
    total++;
    if (bif.req0_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release_ready: req0_ready=%b required 1", bif.req0_ready);
    end
    bif.req0_valid = 1'b0;
  endtask

  task automatic test_single_op(input bit id, input logic [7:0] a, input logic [7:0] b,
                                input string name);
    int lat;
    int exp;
    logic rdy;
    @(negedge clk);
    bif.resp_ready = 1'b1;
    bif.req0_valid = ~id; bif.req1_valid = id;
    if (id) begin bif.req1_a = a; bif.req1_b = b; end
    else    begin bif.req0_a = a; bif.req0_b = b; end
    #1;
    rdy = id ? bif.req1_ready : bif.req0_ready;
    total++;
    if (rdy !== 1'b1) begin
      bad++;
      $display("FAIL %s_ready: ready=%b required 1", name, rdy);
    end
    exp = ref_prod(int'(a), int'(b), stub_beef);
    @(negedge clk);
    bif.req0_valid = 1'b0; bif.req1_valid = 1'b0;
    #1;
    lat = 1;
    while (bif.resp_valid !== 1'b1 && lat < 40) begin
      @(negedge clk); #1;
      lat++;
    end
    total++;
    if (lat != LAT + 1) begin
      bad++;
      $display("FAIL %s_latency: got %0d cycles required %0d", name, lat, LAT + 1);
    end
    total++;
    if (bif.resp_data !== exp[15:0] || bif.resp_id !== id) begin
      bad++;
      $display("FAIL %s_data: data=%h id=%b required data=%h id=%b",
               name, bif.resp_data, bif.resp_id, exp[15:0], id);
    end
    total++;
    if (mul_a !== a || mul_b !== b) begin
      bad++;
      $display("FAIL %s_mul_operands: mul_a=%h mul_b=%h required %h %h", name, mul_a, mul_b, a, b);
    end
    @(negedge clk); #1;
    exp_ops = (exp_ops + 1) & 'hFFFF;
    model_last = int'(id);
    total++;
    if (ops_done !== exp_ops[15:0] || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_complete: ops_done=%h busy=%b required ops_done=%h busy=0",
               name, ops_done, busy, exp_ops[15:0]);
    end
  endtask

  task automatic test_zero_bypass();
    stub_beef = 1'b1;
    test_single_op(1'b1, 8'd0, 8'd37, "bypass_a_zero");
    test_single_op(1'b1, 8'd37, 8'd0, "bypass_b_zero");
    test_single_op(1'b0, 8'd3, 8'd5, "stub_passthrough");
    stub_beef = 1'b0;
  endtask

  task automatic test_random_ops();
    logic [7:0] a, b;
    for (int i = 0; i < 6; i++) begin
      a = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      b = 8'($urandom_range(0, 255));
      test_single_op(1'($urandom_range(0, 1)), a, b, "rand_op");
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] a0, b0, a1, b1;
    int q_id[$], q_a[$], q_b[$];
    int nresp, cyc, last_acc, exp;
    bit got;
    nresp = 0; cyc = 0; last_acc = -1;
    a0 = 8'($urandom_range(1, 255)); b0 = 8'($urandom_range(1, 255));
    a1 = 8'($urandom_range(1, 255)); b1 = 8'($urandom_range(1, 255));
    bif.resp_ready = 1'b1;
    while (nresp < 8 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      bif.req0_valid = 1'b1; bif.req1_valid = 1'b1;
      bif.req0_a = a0; bif.req0_b = b0; bif.req1_a = a1; bif.req1_b = b1;
      #1;
      if (bif.resp_valid === 1'b1 && q_id.size() > 0) begin
        exp = ref_prod(q_a[0], q_b[0], 1'b0);
        total++;
        if (bif.resp_id !== 1'(q_id[0]) || bif.resp_data !== exp[15:0]) begin
          bad++;
          $display("FAIL rr_resp: id=%b data=%h required id=%0d data=%h",
                   bif.resp_id, bif.resp_data, q_id[0], exp[15:0]);
        end
        model_last = q_id[0];
        void'(q_id.pop_front()); void'(q_a.pop_front()); void'(q_b.pop_front());
        nresp++;
        exp_ops = (exp_ops + 1) & 'hFFFF;
      end
      if (bif.req0_ready === 1'b1 || bif.req1_ready === 1'b1) begin
        got = bif.req1_ready;
        total++;
        if ((bif.req0_ready & bif.req1_ready) !== 1'b0 || int'(got) != 1 - model_last) begin
          bad++;
          $display("FAIL rr_grant: ready0=%b ready1=%b required grant %0d",
                   bif.req0_ready, bif.req1_ready, 1 - model_last);
        end
        if (last_acc >= 0) begin
          total++;
          if (cyc - last_acc != LAT + 2) begin
            bad++;
            $display("FAIL rr_spacing: got %0d cycles required %0d", cyc - last_acc, LAT + 2);
          end
        end
        last_acc = cyc;
        q_id.push_back(int'(got));
        q_a.push_back(got ? int'(a1) : int'(a0));
        q_b.push_back(got ? int'(b1) : int'(b0));
        if (got) begin a1 = 8'($urandom_range(1, 255)); b1 = 8'($urandom_range(1, 255)); end
        else     begin a0 = 8'($urandom_range(1, 255)); b0 = 8'($urandom_range(1, 255)); end
      end
    end
    bif.req0_valid = 1'b0; bif.req1_valid = 1'b0;
    total++;
    if (nresp != 8) begin
      bad++;
      $display("FAIL rr_count: got %0d responses required 8", nresp);
    end
    @(negedge clk); #1;
    total++;
    if (ops_done !== exp_ops[15:0]) begin
      bad++;
      $display("FAIL rr_ops_done: ops_done=%h required %h", ops_done, exp_ops[15:0]);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] a, b;
    int n, exp;
    a = 8'($urandom_range(1, 255)); b = 8'($urandom_range(1, 255));
    exp = ref_prod(int'(a), int'(b), 1'b0);
    @(negedge clk);
    bif.resp_ready = 1'b0;
    bif.req0_valid = 1'b1; bif.req1_valid = 1'b0; bif.req0_a = a; bif.req0_b = b;
    @(negedge clk);
    bif.req0_valid = 1'b0;
    #1;
    n = 0;
    while (bif.resp_valid !== 1'b1 && n < 40) begin
      @(negedge clk); #1;
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bif.req0_valid = 1'b1; bif.req1_valid = 1'b1;
      bif.req0_a = 8'($urandom); bif.req0_b = 8'($urandom);
      bif.req1_a = 8'($urandom); bif.req1_b = 8'($urandom);
      #1;
      total++;
      if (bif.resp_valid !== 1'b1 || bif.resp_data !== exp[15:0] || mul_a !== a || mul_b !== b) begin
        bad++;
        $display("FAIL stall_hold: valid=%b data=%h mul=%h/%h required 1 %h %h/%h",
                 bif.resp_valid, bif.resp_data, mul_a, mul_b, exp[15:0], a, b);
      end
      total++;
      if (bif.req0_ready !== 1'b0 || bif.req1_ready !== 1'b0) begin
        bad++;
        $display("FAIL stall_ready: ready0=%b ready1=%b required 0 0", bif.req0_ready, bif.req1_ready);
      end
    end
    bif.req0_valid = 1'b0; bif.req1_valid = 1'b0;
    bif.resp_ready = 1'b1;
    @(negedge clk); #1;
    exp_ops = (exp_ops + 1) & 'hFFFF;
    model_last = 0;
    total++;
    if (ops_done !== exp_ops[15:0] || bif.resp_valid !== 1'b0) begin
      bad++;
      $display("FAIL stall_release: ops_done=%h valid=%b required %h 0", ops_done, bif.resp_valid, exp_ops[15:0]);
    end
    @(negedge clk); #1;
    total++;
    if (ops_done !== exp_ops[15:0]) begin
      bad++;
      $display("FAIL stall_single_count: ops_done=%h required %h", ops_done, exp_ops[15:0]);
    end
  endtask

  task automatic test_reset_midop();
    bit seen;
    int lat;
    @(negedge clk);
    bif4.resp_ready = 1'b1;
    bif4.req0_valid = 1'b1; bif4.req0_a = 8'd9; bif4.req0_b = 8'd7;
    #1;
    total++;
    if (bif4.req0_ready !== 1'b1 || bif4.req1_ready !== 1'b0) begin
      bad++;
      $display("FAIL midrst_accept: ready0=%b ready1=%b required 1 0", bif4.req0_ready, bif4.req1_ready);
    end
    @(negedge clk);
    bif4.req0_valid = 1'b0;
    #1;
    total++;
    if (busy4 !== 1'b1) begin
      bad++;
      $display("FAIL midrst_busy: busy=%b required 1", busy4);
    end
    @(negedge clk);
    rst4 = 1'b1;
    @(negedge clk);
    rst4 = 1'b0;
    #1;
    total++;
    if (busy4 !== 1'b0 || bif4.resp_valid !== 1'b0 || mul_a4 !== 8'd0 || ops_done4 !== 16'd0) begin
      bad++;
      $display("FAIL midrst_state: busy=%b valid=%b mul_a=%h ops=%h required 0 0 00 0000",
               busy4, bif4.resp_valid, mul_a4, ops_done4);
    end
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk); #1;
      if (bif4.resp_valid !== 1'b0) seen = 1'b1;
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL midrst_no_resp: resp_valid seen=1 required 0");
    end
    @(negedge clk);
    bif4.req1_valid = 1'b1; bif4.req1_a = 8'd4; bif4.req1_b = 8'd8;
    @(negedge clk);
    bif4.req1_valid = 1'b0;
    #1;
    lat = 1;
    while (bif4.resp_valid !== 1'b1 && lat < 40) begin
      @(negedge clk); #1;
      lat++;
    end
    total++;
    if (lat != LAT4 + 1 || bif4.resp_data !== 16'd32 || bif4.resp_id !== 1'b1) begin
      bad++;
      $display("FAIL lat4_op: lat=%0d data=%h id=%b required %0d 0020 1",
               lat, bif4.resp_data, bif4.resp_id, LAT4 + 1);
    end
  endtask

  task automatic test_wrap();
    int n;
    @(negedge clk);
    bif.resp_ready = 1'b0;
    bif.req0_valid = 1'b1; bif.req1_valid = 1'b0; bif.req0_a = 8'd2; bif.req0_b = 8'd3;
    @(negedge clk);
    bif.req0_valid = 1'b0;
    #1;
    n = 0;
    while (bif.resp_valid !== 1'b1 && n < 40) begin
      @(negedge clk); #1;
      n++;
    end
    force dut.r_ops_done = 16'hFFFF;
    @(negedge clk);
    release dut.r_ops_done;
    bif.resp_ready = 1'b1;
    @(negedge clk); #1;
    exp_ops = 0;
    model_last = 0;
    total++;
    if (ops_done !== 16'h0000 || bif.resp_valid !== 1'b0) begin
      bad++;
      $display("FAIL ops_wrap: ops_done=%h valid=%b required 0000 0", ops_done, bif.resp_valid);
    end
  endtask

  initial begin
    stub_beef = 1'b0;
    bif4.req0_valid = 1'b0; bif4.req1_valid = 1'b0;
    bif4.req0_a = 8'd0; bif4.req0_b = 8'd0; bif4.req1_a = 8'd0; bif4.req1_b = 8'd0;
    bif4.resp_ready = 1'b1;
    test_reset();
    test_single_op(1'b0, 8'd2, 8'd2, "pow2_2x2");
    test_single_op(1'b0, 8'd16, 8'd8, "pow2_16x8");
    test_zero_bypass();
    test_random_ops();
    test_round_robin();
    test_backpressure();
    test_reset_midop();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
